// File: rtl/sar_integ_ctrl.sv
// sar_integ_ctrl
// SAR sequencer for an ADC whose comparator is a clocked integrating
// amplifier followed by a latch. Each conversion runs in this order:
//   1. Track the input for T_SAMPLE cycles.
//   2. For each bit, MSB first:
//      - integrate for T_INT cycles;
//      - spend one evaluate cycle in which the latch decision is captured.
//   3. Publish the result on a valid/ready port.
// Every output comes straight from a flop.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             conversion request (accepted only when idle and the
//                     output port is free or being drained this cycle)
//   comp_p, comp_n    latch outputs; equal values mean an unresolved decision
//   sample            track switch enable
//   amp_en            integrating amplifier enable (0 = hold / evaluate)
//   dac_code[NBIT]    trial code for the capacitive DAC
//   busy              conversion in progress
//   dout[NBIT]        last conversion result
//   dout_valid        dout holds an unconsumed result
//   dout_ready        downstream accepts dout
//   err_meta          the result on dout contains an unresolved decision
module sar_integ_ctrl #(
  parameter int NBIT     = 8,
  parameter int T_SAMPLE = 2,
  parameter int T_INT    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            comp_p,
  input  logic            comp_n,
  output logic            sample,
  output logic            amp_en,
  output logic [NBIT-1:0] dac_code,
  output logic            busy,
  output logic [NBIT-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            err_meta
);

  localparam int TMAX = (T_SAMPLE > T_INT) ? T_SAMPLE : T_INT;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int KW   = $clog2(NBIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_INTEG,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic            meta, meta_nxt;
  logic [NBIT-1:0] code_nxt, dout_nxt;
  logic            err_meta_nxt, dout_valid_nxt;
  logic            sample_nxt, amp_en_nxt, busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      k          <= '0;
      meta       <= 1'b0;
      dac_code   <= '0;
      dout       <= '0;
      err_meta   <= 1'b0;
      dout_valid <= 1'b0;
      sample     <= 1'b0;
      amp_en     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      k          <= k_nxt;
      meta       <= meta_nxt;
      dac_code   <= code_nxt;
      dout       <= dout_nxt;
      err_meta   <= err_meta_nxt;
      dout_valid <= dout_valid_nxt;
      sample     <= sample_nxt;
      amp_en     <= amp_en_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-output logic. Outputs are derived from the next
  // state so that the registered versions line up with the state register.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    k_nxt          = k;
    meta_nxt       = meta;
    code_nxt       = dac_code;
    dout_nxt       = dout;
    err_meta_nxt   = err_meta;
    dout_valid_nxt = dout_valid & ~dout_ready;

    case (state)
      S_IDLE: begin
        // A result being drained this cycle frees the port for a new start.
        if (start && (!dout_valid || dout_ready)) begin
          state_nxt = S_SAMPLE;
          cnt_nxt   = '0;
          k_nxt     = KW'(NBIT - 1);
          code_nxt  = '0;
          code_nxt[NBIT-1] = 1'b1;
          meta_nxt  = 1'b0;
        end
      end
      S_SAMPLE: begin
        if (cnt == CW'(T_SAMPLE - 1)) begin
          state_nxt = S_INTEG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_INTEG: begin
        if (cnt == CW'(T_INT - 1)) begin
          state_nxt = S_DECIDE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DECIDE: begin
        // An unresolved latch (comp_p == comp_n) clears the bit and flags it.
        code_nxt[k] = comp_p & ~comp_n;
        if (comp_p == comp_n) begin
          meta_nxt = 1'b1;
        end
        if (k != '0) begin
          code_nxt[k - KW'(1)] = 1'b1;
          k_nxt     = k - KW'(1);
          state_nxt = S_INTEG;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        dout_nxt       = dac_code;
        err_meta_nxt   = meta;
        dout_valid_nxt = 1'b1;
        code_nxt       = '0;
        state_nxt      = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    sample_nxt = (state_nxt == S_SAMPLE);
    amp_en_nxt = (state_nxt == S_INTEG);
    busy_nxt   = (state_nxt != S_IDLE);
  end

endmodule

// File: doc/sar_integ_ctrl.md
Name: sar_integ_ctrl

Overview:
- Digital SAR controller at the output end of the clocked integrating amplifier in the SAR ADC example.
- Drives the sample switch, the amplifier integrate enable and the trial DAC code.
- Captures the latch decision (comp_p/comp_n) that follows the amplifier each bit cycle and builds the result MSB-first.
- Delivers each finished conversion on a valid/ready output port, for use in mLingua SAR ADC benches with the PWL amplifier model.

Parameters:
NBIT, 8, resolution in bits; legal range 2..16
T_SAMPLE, 2, cycles the sample output is held high per conversion; must be >=1
T_INT, 1, cycles amp_en is held high per bit (integration window); must be >=1

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous active-high reset
start  input  1  conversion request, sampled on clk
comp_p  input  1  latch positive output; 1 means vin >= DAC trial
comp_n  input  1  latch negative output; complement of comp_p when resolved
sample  output  1  input track switch enable
amp_en  output  1  integrating amp enable (1 = integrate, 0 = hold/latch evaluate)
dac_code  output  NBIT  current trial code to the capacitive DAC
busy  output  1  conversion in progress
dout  output  NBIT  conversion result
dout_valid  output  1  dout holds an unconsumed result
dout_ready  input  1  downstream accepts dout
err_meta  output  1  at least one unresolved decision in the result on dout

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. All outputs 0: sample, amp_en, dac_code, busy, dout, dout_valid, err_meta.
  - Applies mid-conversion. Any partial result is discarded; any pending dout is dropped.
- Every output is registered (no combinational input-to-output paths).
- Start acceptance: start is accepted in IDLE when dout_valid==0, or when dout_valid==1 and dout_ready==1 in the same cycle.
  - If not accepted, start is ignored. There is no queuing.
- Handshake: dout_valid&dout_ready at an edge clears dout_valid; dout is held. dout and err_meta never change while dout_valid==1.
- FSM states:
  - IDLE -> SAMPLE on accepted start.
  - SAMPLE: sample=1, busy=1, dac_code=1<<(NBIT-1), bit index k=NBIT-1. Lasts T_SAMPLE cycles, then -> INTEG.
  - INTEG: amp_en=1, sample=0, dac_code=trial. Lasts T_INT cycles, then -> DECIDE.
  - DECIDE: amp_en=0, 1 cycle. At the closing edge, comp is registered:
    - comp_p=1, comp_n=0: bit k kept 1.
    - comp_p=0, comp_n=1: bit k cleared.
    - comp_p==comp_n: bit k cleared and an internal meta flag is set (unresolved decision).
    - If k>0: set bit k-1, decrement k, -> INTEG. If k==0: -> DONE.
  - DONE: 1 cycle, busy=1, dac_code=final code. At the closing edge: dout<=code, err_meta<=meta flag, dout_valid<=1, busy<=0. Then -> IDLE.
- The meta flag is cleared on entry to SAMPLE.
- Timing: start accepted at edge E0 gives sample=1 in the cycle after E0. busy stays high for T_SAMPLE+NBIT*(T_INT+1)+1 cycles (19 at defaults). dout_valid rises in the same cycle busy falls.
- Successive trial codes per bit are observable on dac_code during INTEG/DECIDE.
- comp inputs are ignored outside DECIDE.
- start asserted while busy is ignored.

Test Plan:
1. rst=1 for 3 cycles at arbitrary state -> all outputs 0 the cycle after the first rst edge; start held high during rst -> no conversion.
2. Ideal comparator model comp_p=(0xA5>=dac_code), comp_n=~comp_p; one start pulse -> dac_code in DECIDE cycles 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; dout=0xA5, err_meta=0; dout_valid rises 19 cycles after start edge.
3. Ideal comparator with vin 0x00, then 0xFF, dout_ready=1 -> dout=0x00 then 0xFF; dout_valid high exactly 1 cycle each.
4. vin 0xFF with comp_p=comp_n=1 forced in the bit-5 DECIDE -> dout=0xDF, err_meta=1; next clean conversion of 0xFF -> err_meta=0.
5. dout_ready=0 for 10 cycles after a result, start pulsed repeatedly -> no sample/busy, dout stable. start and dout_ready both 1 in one cycle -> dout_valid clears and sample=1 the next cycle.
6. rst pulsed during bit-3 INTEG -> next cycle busy=0, amp_en=0, dac_code=0. A fresh start with vin 0x3C -> dout=0x3C.
